// File: rtl/ovrd_clamp_sequencer.sv
// Overdrive soft-clamp sequencer: pre-gain, then f(x) = (3x + x^3)/4 clamped to +/-3/4,
// evaluated on one time-shared fixed-point multiplier behind valid/ready handshakes.
module ovrd_clamp_sequencer #(
  parameter int bits_per_level = 12,
  parameter int fxp_size       = 32,
  parameter int cnt_size       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic signed [fxp_size-1:0] i_sample,
  input  logic signed [fxp_size-1:0] i_gain,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [fxp_size-1:0] o_sample,
  output logic                       o_clipped,
  output logic [cnt_size-1:0]        o_clip_count,
  input  logic                       i_clear_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAIN   = 3'd1;
  localparam logic [2:0] S_SQUARE = 3'd2;
  localparam logic [2:0] S_CUBE   = 3'd3;
  localparam logic [2:0] S_SUM    = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam int PW = 2 * fxp_size;
  localparam logic signed [PW-1:0] ONE_W     = PW'(1) << bits_per_level;
  localparam logic signed [PW-1:0] NEG_ONE_W = -ONE_W;
  localparam int CLAMP_I = (3 * (1 << bits_per_level)) / 4;
  localparam logic signed [fxp_size-1:0] CLAMP_POS = fxp_size'(CLAMP_I);
  localparam logic signed [fxp_size-1:0] CLAMP_NEG = -CLAMP_POS;

  logic [2:0]                 state_q, state_d;
  logic signed [fxp_size-1:0] sample_q, sample_d;
  logic signed [fxp_size-1:0] gain_q, gain_d;
  logic signed [fxp_size-1:0] x_q, x_d;
  logic signed [fxp_size-1:0] sq_q, sq_d;
  logic signed [fxp_size-1:0] cu_q, cu_d;
  logic signed [fxp_size-1:0] result_q, result_d;
  logic                       clipped_q, clipped_d;
  logic [cnt_size-1:0]        cnt_q, cnt_d;

  logic signed [fxp_size-1:0] mul_a, mul_b;
  logic signed [PW-1:0]       mul_a_w, mul_b_w, prod, prod_sh;
  logic signed [fxp_size+1:0] x_ext, cu_ext, poly_sum;

  // Single multiplier: operands steered by the current step.
  always_comb begin
    mul_a = x_q;
    mul_b = x_q;
    case (state_q)
      S_GAIN: begin
        mul_a = sample_q;
        mul_b = gain_q;
      end
      S_CUBE: begin
        mul_a = sq_q;
        mul_b = x_q;
      end
      default: ;
    endcase
  end

  assign mul_a_w = {{fxp_size{mul_a[fxp_size-1]}}, mul_a};
  assign mul_b_w = {{fxp_size{mul_b[fxp_size-1]}}, mul_b};
  assign prod    = mul_a_w * mul_b_w;
  assign prod_sh = prod >>> bits_per_level;

  assign x_ext    = {{2{x_q[fxp_size-1]}}, x_q};
  assign cu_ext   = {{2{cu_q[fxp_size-1]}}, cu_q};
  assign poly_sum = (x_ext <<< 1) + x_ext + cu_ext;

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    gain_d    = gain_q;
    x_d       = x_q;
    sq_d      = sq_q;
    cu_d      = cu_q;
    result_d  = result_q;
    clipped_d = clipped_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          sample_d = i_sample;
          gain_d   = i_gain;
          state_d  = S_GAIN;
        end
      end
      // Threshold test uses the untruncated product so overflow cannot wrap into the soft path.
      S_GAIN: begin
        if (prod_sh >= ONE_W) begin
          result_d  = CLAMP_POS;
          clipped_d = 1'b1;
          state_d   = S_OUT;
        end else if (prod_sh <= NEG_ONE_W) begin
          result_d  = CLAMP_NEG;
          clipped_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          x_d     = prod_sh[fxp_size-1:0];
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        sq_d    = prod_sh[fxp_size-1:0];
        state_d = S_CUBE;
      end
      S_CUBE: begin
        cu_d    = prod_sh[fxp_size-1:0];
        state_d = S_SUM;
      end
      S_SUM: begin
        result_d  = poly_sum[fxp_size+1:2];
        clipped_d = 1'b0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear_count) begin
      cnt_d = '0;
    end else if (state_q == S_OUT && i_ready && clipped_q && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sample_q  <= '0;
      gain_q    <= '0;
      x_q       <= '0;
      sq_q      <= '0;
      cu_q      <= '0;
      result_q  <= '0;
      clipped_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      gain_q    <= gain_d;
      x_q       <= x_d;
      sq_q      <= sq_d;
      cu_q      <= cu_d;
      result_q  <= result_d;
      clipped_q <= clipped_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_valid      = (state_q == S_OUT);
  assign o_sample     = result_q;
  assign o_clipped    = clipped_q;
  assign o_clip_count = cnt_q;

endmodule

// File: tb/tb_ovrd_clamp_sequencer.sv
// Directed bench for ovrd_clamp_sequencer: scoreboarded results, latency, backpressure,
// clip counter saturation/clear and mid-sequence asynchronous reset.
module tb_ovrd_clamp_sequencer;

  localparam int CNT  = 4;
  localparam int CMAX = (1 << CNT) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_valid;
  logic               o_ready;
  logic signed [31:0] i_sample;
  logic signed [31:0] i_gain;
  logic               o_valid;
  logic               i_ready;
  logic signed [31:0] o_sample;
  logic               o_clipped;
  logic [CNT-1:0]     o_clip_count;
  logic               i_clear_count;

  typedef struct {
    logic signed [31:0] s;
    logic               c;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  ovrd_clamp_sequencer #(
    .bits_per_level(12),
    .fxp_size(32),
    .cnt_size(CNT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_sample(i_sample),
    .i_gain(i_gain),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sample(o_sample),
    .o_clipped(o_clipped),
    .o_clip_count(o_clip_count),
    .i_clear_count(i_clear_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference f(x) with pre-gain, in 64-bit integer arithmetic.
  function automatic logic signed [31:0] model(input logic signed [31:0] s, input logic signed [31:0] g,
                                               output logic c);
    longint p, sq, cu, r;
    p = (longint'(s) * longint'(g)) >>> 12;
    c = 1'b1;
    if (p >= 4096) return 32'sd3072;
    if (p <= -4096) return -32'sd3072;
    c  = 1'b0;
    sq = (p * p) >>> 12;
    cu = (sq * p) >>> 12;
    r  = (3 * p + cu) >>> 2;
    return r[31:0];
  endfunction

  task automatic wait_result(output int lat);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input logic signed [31:0] s, input logic signed [31:0] g,
                      input logic signed [31:0] es, input logic ec, input int el, input bit clr);
    exp_t e;
    int   lat;
    @(negedge clk);
    check("ready_idle", o_ready, 1);
    i_valid  = 1'b1;
    i_sample = s;
    i_gain   = g;
    e.s = es; e.c = ec; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
    wait_result(lat);
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("sample", o_sample, e.s);
    check("clipped", o_clipped, e.c);
    i_clear_count = clr;
    @(negedge clk);
    i_clear_count = 1'b0;
    if (clr) exp_cnt = 0;
    else if (e.c && exp_cnt < CMAX) exp_cnt++;
    check("valid_drop", o_valid, 0);
    check("clip_count", o_clip_count, exp_cnt);
  endtask

  task automatic send_model(input logic signed [31:0] s, input logic signed [31:0] g);
    logic signed [31:0] es;
    logic               ec;
    es = model(s, g, ec);
    send(s, g, es, ec, ec ? 2 : 5, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   lat;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clear_count = 1'b0;
    i_sample = '0; i_gain = '0;
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_sample", o_sample, 0);
    check("rst_clipped", o_clipped, 0);
    check("rst_count", o_clip_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", o_ready, 1);

    // Soft path and floor behaviour
    send(2048, 4096, 1664, 1'b0, 5, 1'b0);
    send(-2048, 4096, -1664, 1'b0, 5, 1'b0);
    send(-1, 4096, -1, 1'b0, 5, 1'b0);

    // Clamp thresholds
    send(4096, 4096, 3072, 1'b1, 2, 1'b0);
    send(-4096, 4096, -3072, 1'b1, 2, 1'b0);
    send(2048, 8192, 3072, 1'b1, 2, 1'b0);
    check("count_after_three", o_clip_count, 3);

    // Gain-product overflow, zero gain, just-inside boundaries
    send(32'sh7FFFFFFF, 32'sh7FFFFFFF, 3072, 1'b1, 2, 1'b0);
    send(12345, 0, 0, 1'b0, 5, 1'b0);
    send_model(4095, 4096);
    send_model(-4095, 4096);
    for (int i = 0; i < 4; i++) begin
      send_model($signed($urandom_range(0, 16383)) - 8192, 32'sd2048);
    end

    // Backpressure: result held, accept blocked, new i_valid ignored
    i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b1; i_sample = 4096; i_gain = 8192;
    e.s = 3072; e.c = 1'b1; e.lat = 2;
    sb.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
    wait_result(lat);
    e = sb.pop_front();
    check("bp_latency", lat, e.lat);
    check("bp_sample", o_sample, e.s);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_sample = 2048; i_gain = 4096;
      @(negedge clk);
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_sample", o_sample, e.s);
      check("bp_hold_clipped", o_clipped, e.c);
      check("bp_hold_ready", o_ready, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("bp_release_valid", o_valid, 0);
    check("bp_release_ready", o_ready, 1);
    check("bp_release_count", o_clip_count, exp_cnt);
    @(negedge clk);
    check("bp_no_extra", o_valid, 0);
    check("bp_sample_kept", o_sample, 3072);

    // Saturation of the clip counter
    while (exp_cnt < CMAX) send(-8192, 4096, -3072, 1'b1, 2, 1'b0);
    send(8192, 4096, 3072, 1'b1, 2, 1'b0);
    send(-8192, 4096, -3072, 1'b1, 2, 1'b0);
    check("count_saturated", o_clip_count, CMAX);

    // Clear coincident with an increment
    send(4096, 4096, 3072, 1'b1, 2, 1'b1);
    check("count_cleared", o_clip_count, 0);
    send(4096, 4096, 3072, 1'b1, 2, 1'b0);

    // Asynchronous reset while in CUBE
    @(negedge clk);
    i_valid = 1'b1; i_sample = 2048; i_gain = 4096;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cube_busy", o_ready, 0);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_sample", o_sample, 0);
    check("mid_rst_clipped", o_clipped, 0);
    check("mid_rst_count", o_clip_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2048, 4096, 1664, 1'b0, 5, 1'b0);
    send(-4096, 4096, -3072, 1'b1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
